motor_pwm_decoder: RTL and testbench
====================================

Name: motor_pwm_decoder

Overview:
- Receive-side counterpart of the motor PWM drive path.
- Observes the four H-bridge gate signals (fwd/rev, left/right) and reconstructs the signed-magnitude 11-bit wheel commands that produced them.
- Also reports the per-side drive mode and shoot-through faults.
- Sits between the motor driver outputs and the telemetry/self-check logic; used for closed-loop sanity checks and bench loopback.

Parameters:
- PERIOD_BITS, 10: PWM counter width. Measurement window is 2^PERIOD_BITS clocks; commands are PERIOD_BITS+1 bits wide.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fwd_lft  in  1  left forward gate drive
- rev_lft  in  1  left reverse gate drive
- fwd_rht  in  1  right forward gate drive
- rev_rht  in  1  right reverse gate drive
- lft_cmd  out  PERIOD_BITS+1  decoded left command; MSB = reverse, low bits = duty
- rht_cmd  out  PERIOD_BITS+1  decoded right command, same format
- lft_mode  out  2  left mode: 00 BRAKE, 01 FWD, 10 REV, 11 FAULT
- rht_mode  out  2  right mode, same encoding
- cmd_vld  out  1  one-cycle pulse when new commands/modes are posted

Behaviour:
- Reset: lft_cmd = rht_cmd = 0, both modes = BRAKE, cmd_vld = 0, window counter = 0, all accumulators = 0.
- Window counter:
  - Free-running, PERIOD_BITS wide, starts at 0 on reset release, aligned with the drive PWM counters.
  - A window is counter values 0 through 2^PERIOD_BITS-1 and wraps with no gap.
- Accumulators:
  - Per side, two (PERIOD_BITS+1)-bit counters: fwd_hi and rev_hi. Each counts clocks with its input high; the width holds the full-window value 1024.
  - Per side, a both_hi counter counts clocks with fwd and rev high together.
  - Counters saturate, never wrap.
- Window end (counter = max): classify each side using the values including that cycle's sample.
  - both_hi = 2^PERIOD_BITS → BRAKE, cmd = 0.
  - both_hi ≠ 0 and not full window → FAULT.
  - fwd_hi > 0 and rev_hi > 0 with both_hi = 0 → FAULT.
  - fwd_hi > 0, rev_hi = 0 → FWD, cmd = {0, fwd_hi[PERIOD_BITS-1:0]}.
  - rev_hi > 0, fwd_hi = 0 → REV, cmd = {1, rev_hi[PERIOD_BITS-1:0]}.
  - Both zero all window → REV, cmd = {1, 0} (only the reverse-zero-duty command produces all-low).
- FAULT: mode = 11, cmd holds its previous value.
- Latency:
  - Registered results and a cmd_vld pulse appear on the clock after the window's last sample (counter back at 0).
  - Accumulators clear on that same edge, so the new window's first sample is counted, not lost.
- Mid-window input change: that window decodes whatever counts accumulated, with no guarantee of correctness. The next full window must be exact.
- Reset mid-window: all state returns to reset values immediately. No cmd_vld until a full window completes after release.
- Sides are independent; one cmd_vld covers both.

Optional Feature:
- Macro: MOTOR_PWM_DEC_SYNC_EN.
- Defined:
  - Each gate input passes through a 2-flop synchronizer before the accumulators, for inputs from pads or another clock domain.
  - The window counter's reset-release start is delayed 2 clocks to stay aligned with the synchronized samples.
  - cmd_vld latency grows by 2 clocks relative to the raw drive.
- Undefined: inputs are sampled directly, with the latency stated above.

Decomposition:
- Shared package holds:
  - mode localparams BRAKE = 2'b00, FWD = 2'b01, REV = 2'b10, FAULT = 2'b11 (FWD/REV/BRAKE matching the drive side's encoding);
  - the default PERIOD_BITS.
- One sub-module, motor_pwm_chan: per-side accumulators, classifier and output registers, instantiated twice.
- The top level owns the window counter, the cmd_vld pulse and the optional synchronizers.

Test Plan:
- Loopback from the drive block, lft = 11'h000, rht = 11'h000 → after the first window: lft_cmd = rht_cmd = 0, modes BRAKE, cmd_vld high 1 cycle at counter 0.
- lft = 11'h180, rht = 11'h5FF → lft_cmd = 11'h180 FWD, rht_cmd = 11'h5FF REV, stable across 3 consecutive windows, cmd_vld every 1024 clocks.
- Boundaries: lft = 11'h3FF → 11'h3FF FWD; rht = 11'h400 → 11'h400 REV; lft = 11'h001 → 11'h001 FWD.
- Force fwd_lft = rev_lft = 1 for 10 clocks inside a FWD 11'h100 window → lft_mode FAULT, lft_cmd holds 11'h100, rht unaffected. The next clean window returns FWD 11'h100.
- Assert rst_n low at counter = 500 for 3 clocks → outputs 0/BRAKE at once. First cmd_vld exactly 1025 clocks after release, correctly decoded.
- Switch lft from 11'h200 to 11'h600 mid-window → the following full window reports 11'h600 REV. The mixed window reports any value but cmd_vld timing is unchanged.

Source files
------------

// File: rtl/motor_pwm_decoder_pkg.sv
// Shared definitions for the motor PWM decoder: the drive-mode encoding
// (same codes as the drive side) and the default PWM counter width.
package motor_pwm_decoder_pkg;

  localparam int PERIOD_BITS_DEF = 10;

  localparam logic [1:0] BRAKE = 2'b00;
  localparam logic [1:0] FWD   = 2'b01;
  localparam logic [1:0] REV   = 2'b10;
  localparam logic [1:0] FAULT = 2'b11;

endpackage

// File: rtl/motor_pwm_chan.sv
// One H-bridge side of the PWM decoder: counts forward-high, reverse-high
// and both-high clocks over a measurement window, then classifies the
// window into a mode and a signed-magnitude command.
module motor_pwm_chan
  import motor_pwm_decoder_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd,
  input  logic                 rev,
  input  logic                 win_end,
  output logic [PERIOD_BITS:0] cmd,
  output logic [1:0]           mode
);

  localparam logic [PERIOD_BITS:0] FULL = {1'b1, {PERIOD_BITS{1'b0}}};
  localparam logic [PERIOD_BITS:0] SAT  = {(PERIOD_BITS + 1){1'b1}};
  localparam logic [PERIOD_BITS:0] ONE  = {{PERIOD_BITS{1'b0}}, 1'b1};

  logic [PERIOD_BITS:0] fwd_hi_q, fwd_hi_d;
  logic [PERIOD_BITS:0] rev_hi_q, rev_hi_d;
  logic [PERIOD_BITS:0] both_hi_q, both_hi_d;
  logic [PERIOD_BITS:0] fwd_sum, rev_sum, both_sum;
  logic [PERIOD_BITS:0] cmd_q, cmd_d;
  logic [1:0]           mode_q, mode_d;

  // Saturating accumulation; at window end classify using the totals that
  // include this cycle's sample, and restart the counts from zero.
  always_comb begin
    fwd_sum  = (fwd && (fwd_hi_q != SAT)) ? fwd_hi_q + ONE : fwd_hi_q;
    rev_sum  = (rev && (rev_hi_q != SAT)) ? rev_hi_q + ONE : rev_hi_q;
    both_sum = (fwd && rev && (both_hi_q != SAT)) ? both_hi_q + ONE : both_hi_q;
    fwd_hi_d  = fwd_sum;
    rev_hi_d  = rev_sum;
    both_hi_d = both_sum;
    cmd_d     = cmd_q;
    mode_d    = mode_q;
    if (win_end) begin
      fwd_hi_d  = '0;
      rev_hi_d  = '0;
      both_hi_d = '0;
      if (both_sum == FULL) begin
        mode_d = BRAKE;
        cmd_d  = '0;
      end else if ((both_sum != '0) || ((fwd_sum != '0) && (rev_sum != '0))) begin
        // Shoot-through or mixed drive: flag it, keep the last good command.
        mode_d = FAULT;
      end else if (fwd_sum != '0) begin
        mode_d = FWD;
        cmd_d  = {1'b0, fwd_sum[PERIOD_BITS-1:0]};
      end else begin
        // Reverse duty, including the all-low reverse-zero command.
        mode_d = REV;
        cmd_d  = {1'b1, rev_sum[PERIOD_BITS-1:0]};
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hi_q  <= '0;
      rev_hi_q  <= '0;
      both_hi_q <= '0;
      cmd_q     <= '0;
      mode_q    <= BRAKE;
    end else begin
      fwd_hi_q  <= fwd_hi_d;
      rev_hi_q  <= rev_hi_d;
      both_hi_q <= both_hi_d;
      cmd_q     <= cmd_d;
      mode_q    <= mode_d;
    end
  end

  assign cmd  = cmd_q;
  assign mode = mode_q;

endmodule

// File: rtl/motor_pwm_decoder.sv
// Motor PWM decoder top: reconstructs left/right wheel commands and drive
// modes from the four H-bridge gate signals, one result per window of
// 2^PERIOD_BITS clocks.
// Optional build macro MOTOR_PWM_DEC_SYNC_EN adds 2-flop input synchronizers
// and delays the window counter start by 2 clocks to stay aligned.
module motor_pwm_decoder
  import motor_pwm_decoder_pkg::*;
#(
  parameter int PERIOD_BITS = PERIOD_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd_lft,
  input  logic                 rev_lft,
  input  logic                 fwd_rht,
  input  logic                 rev_rht,
  output logic [PERIOD_BITS:0] lft_cmd,
  output logic [PERIOD_BITS:0] rht_cmd,
  output logic [1:0]           lft_mode,
  output logic [1:0]           rht_mode,
  output logic                 cmd_vld
);

  localparam logic [PERIOD_BITS-1:0] CNT_ONE = {{(PERIOD_BITS - 1){1'b0}}, 1'b1};
  localparam logic [PERIOD_BITS-1:0] CNT_MAX = {PERIOD_BITS{1'b1}};

  // Gate bundle order: {fwd_lft, rev_lft, fwd_rht, rev_rht}
  logic [3:0]             gate_raw, gate;
  logic                   run;
  logic                   win_end;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic                   cmd_vld_q, cmd_vld_d;

  assign gate_raw = {fwd_lft, rev_lft, fwd_rht, rev_rht};

`ifdef MOTOR_PWM_DEC_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  logic [1:0] start_q, start_d;

  // Hold the window counter at 0 until the synchronizer pipeline is full.
  always_comb begin
    start_d = (start_q == 2'd2) ? start_q : start_q + 2'd1;
  end

  // Two-flop synchronizers and start-delay register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      start_q <= '0;
    end else begin
      sync1_q <= gate_raw;
      sync2_q <= sync1_q;
      start_q <= start_d;
    end
  end

  assign gate = sync2_q;
  assign run  = (start_q == 2'd2);
`else
  assign gate = gate_raw;
  assign run  = 1'b1;
`endif

  // Free-running window counter; results post on the edge after its maximum.
  always_comb begin
    win_end   = run && (cnt_q == CNT_MAX);
    cnt_d     = run ? cnt_q + CNT_ONE : cnt_q;
    cmd_vld_d = win_end;
  end

  // Window counter and result-valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cmd_vld_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cmd_vld_q <= cmd_vld_d;
    end
  end

  assign cmd_vld = cmd_vld_q;

  motor_pwm_chan #(.PERIOD_BITS(PERIOD_BITS)) u_chan_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .fwd     (gate[3]),
    .rev     (gate[2]),
    .win_end (win_end),
    .cmd     (lft_cmd),
    .mode    (lft_mode)
  );

  motor_pwm_chan #(.PERIOD_BITS(PERIOD_BITS)) u_chan_rht (
    .clk     (clk),
    .rst_n   (rst_n),
    .fwd     (gate[1]),
    .rev     (gate[0]),
    .win_end (win_end),
    .cmd     (rht_cmd),
    .mode    (rht_mode)
  );

endmodule

// File: tb/tb_motor_pwm_decoder.sv
// Bench for motor_pwm_decoder (default build, no input synchronizers).
// A behavioural drive block turns wheel commands into gate waveforms; the
// stimulus queues the expected decode for each window and a monitor checks
// every cmd_vld against the queue.
module tb_motor_pwm_decoder;
  import motor_pwm_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fwd_lft, rev_lft, fwd_rht, rev_rht;
  logic [10:0] lft_cmd, rht_cmd;
  logic [1:0]  lft_mode, rht_mode;
  logic        cmd_vld;

  logic [10:0] lcmd, rcmd;
  logic        frc_lft;
  logic [9:0]  drv_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [10:0] l;
    logic [10:0] r;
    logic [1:0]  lm;
    logic [1:0]  rm;
    bit          care;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  motor_pwm_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fwd_lft  (fwd_lft),
    .rev_lft  (rev_lft),
    .fwd_rht  (fwd_rht),
    .rev_rht  (rev_rht),
    .lft_cmd  (lft_cmd),
    .rht_cmd  (rht_cmd),
    .lft_mode (lft_mode),
    .rht_mode (rht_mode),
    .cmd_vld  (cmd_vld)
  );

  // Drive-side PWM counter, reset together with the decoder.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) drv_cnt <= '0;
    else        drv_cnt <= drv_cnt + 10'd1;
  end

  // Drive encoding: zero command brakes (both gates high all period),
  // otherwise the selected gate is high while counter < duty.
  function automatic logic [1:0] drive(input logic [10:0] c, input logic [9:0] n);
    logic [9:0] duty;
    duty = c[9:0];
    if (c == 11'h000) return 2'b11;
    if (c[10])        return {1'b0, (n < duty)};
    return {(n < duty), 1'b0};
  endfunction

  always_comb begin
    {fwd_lft, rev_lft} = frc_lft ? 2'b11 : drive(lcmd, drv_cnt);
    {fwd_rht, rev_rht} = drive(rcmd, drv_cnt);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every result pulse must land at counter 0 and match the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && cmd_vld === 1'b1) begin
      exp_t e;
      check("vld_phase", {22'd0, drv_cnt}, 32'd0);
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vld_unexpected: got cmd_vld with empty scoreboard expected none");
      end else begin
        e = sb_q.pop_front();
        if (e.care) begin
          check("lft_cmd",  {21'd0, lft_cmd},  {21'd0, e.l});
          check("rht_cmd",  {21'd0, rht_cmd},  {21'd0, e.r});
          check("lft_mode", {30'd0, lft_mode}, {30'd0, e.lm});
          check("rht_mode", {30'd0, rht_mode}, {30'd0, e.rm});
        end
      end
    end
  end

  // Apply commands at a counter-0 negedge and queue that window's result.
  task automatic set_win(input logic [10:0] l, input logic [10:0] r,
                         input logic [10:0] el, input logic [1:0] elm,
                         input logic [10:0] er, input logic [1:0] erm,
                         input bit care);
    exp_t e;
    lcmd = l;
    rcmd = r;
    e.l = el; e.lm = elm; e.r = er; e.rm = erm; e.care = care;
    sb_q.push_back(e);
  endtask

  task automatic wait_cnt(input logic [9:0] v);
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (drv_cnt != v && i < 3000);
    if (drv_cnt != v) begin
      checks++;
      failures++;
      $display("FAIL wait_timeout: got counter %0d expected %0d", drv_cnt, v);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_lft_cmd",  {21'd0, lft_cmd},  32'd0);
    check("rst_rht_cmd",  {21'd0, rht_cmd},  32'd0);
    check("rst_lft_mode", {30'd0, lft_mode}, {30'd0, BRAKE});
    check("rst_rht_mode", {30'd0, rht_mode}, {30'd0, BRAKE});
    check("rst_cmd_vld",  {31'd0, cmd_vld},  32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    lcmd    = 11'h000;
    rcmd    = 11'h000;
    frc_lft = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Brake loopback on both sides.
    rst_n = 1'b1;
    set_win(11'h000, 11'h000, 11'h000, BRAKE, 11'h000, BRAKE, 1'b1);
    wait_cnt(0);

    // Steady forward/reverse over three windows.
    for (int k = 0; k < 3; k++) begin
      set_win(11'h180, 11'h5FF, 11'h180, FWD, 11'h5FF, REV, 1'b1);
      wait_cnt(0);
    end

    // Duty boundaries: max forward, reverse zero (all low), minimum forward.
    set_win(11'h3FF, 11'h400, 11'h3FF, FWD, 11'h400, REV, 1'b1);
    wait_cnt(0);
    set_win(11'h001, 11'h001, 11'h001, FWD, 11'h001, FWD, 1'b1);
    wait_cnt(0);

    // Shoot-through for 10 clocks on the left: FAULT, command held.
    set_win(11'h100, 11'h2AA, 11'h100, FWD, 11'h2AA, FWD, 1'b1);
    wait_cnt(0);
    set_win(11'h100, 11'h2AA, 11'h100, FAULT, 11'h2AA, FWD, 1'b1);
    wait_cnt(100);
    frc_lft = 1'b1;
    wait_cnt(110);
    frc_lft = 1'b0;
    wait_cnt(0);
    set_win(11'h100, 11'h2AA, 11'h100, FWD, 11'h2AA, FWD, 1'b1);
    wait_cnt(0);

    // Mid-window direction change: mixed window unchecked, next one exact.
    set_win(11'h200, 11'h455, 11'h200, FWD, 11'h455, REV, 1'b1);
    wait_cnt(0);
    set_win(11'h200, 11'h455, 11'h000, BRAKE, 11'h000, BRAKE, 1'b0);
    wait_cnt(300);
    lcmd = 11'h600;
    wait_cnt(0);
    set_win(11'h600, 11'h455, 11'h600, REV, 11'h455, REV, 1'b1);
    wait_cnt(0);

    // Reset at counter 500 for 3 clocks; first result after a full window.
    set_win(11'h155, 11'h4AA, 11'h155, FWD, 11'h4AA, REV, 1'b1);
    wait_cnt(500);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_win(11'h155, 11'h4AA, 11'h155, FWD, 11'h4AA, REV, 1'b1);
    // Release falls between edges, so cmd_vld is seen in the 1025th clock
    // period after release, i.e. after 1024 rising edges.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_vld !== 1'b1 && n < 2000);
    check("vld_latency", n, 32'd1024);

    set_win(11'h155, 11'h000, 11'h155, FWD, 11'h000, BRAKE, 1'b1);
    wait_cnt(0);
    repeat (2) @(negedge clk);
    check("sb_pending", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
